// File: rtl/ecc_sram_scrub_ctrl.sv
// ecc_sram_scrub_ctrl: arbitrates host reads and background scrubs of a SECDED SRAM,
// returns corrected data, writes back single-bit corrections and logs errors.
`default_nettype none

module ecc_sram_scrub_ctrl #(
    parameter int ADDR_W         = 10,
    parameter int SCRUB_INTERVAL = 1024,
    parameter int CNT_W          = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_req,
    input  logic [ADDR_W-1:0] host_addr,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [63:0]       host_rdata,
    output logic [1:0]        host_err,
    input  logic              scrub_en,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_re,
    output logic              sram_we,
    output logic [63:0]       sram_wdata,
    output logic [7:0]        sram_wcheck,
    input  logic [63:0]       sram_rdata,
    input  logic [7:0]        sram_rcheck,
    output logic [71:0]       dec_word,
    input  logic [63:0]       dec_data,
    input  logic [7:0]        dec_check,
    input  logic              dec_sec,
    input  logic              dec_ded,
    output logic [CNT_W-1:0]  sec_cnt,
    output logic [CNT_W-1:0]  ded_cnt,
    output logic [ADDR_W-1:0] ded_addr
);

    localparam int                TMR_W      = $clog2(SCRUB_INTERVAL);
    localparam logic [TMR_W-1:0]  C_TMR_LAST = TMR_W'(SCRUB_INTERVAL - 1);
    localparam logic [CNT_W-1:0]  C_CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_CHECK = 2'd2,
        ST_WB    = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_host_win;
    logic                w_scrub_win;

    logic [ADDR_W-1:0]   r_addr;
    logic                r_is_host;
    logic                r_last_host;
    logic [ADDR_W-1:0]   r_scrub_addr;
    logic [TMR_W-1:0]    r_timer;
    logic                r_scrub_pend;
    logic [63:0]         r_rdata;
    logic [7:0]          r_wcheck;
    logic [1:0]          r_err;
    logic                r_rvalid;
    logic [CNT_W-1:0]    r_sec_cnt;
    logic [CNT_W-1:0]    r_ded_cnt;
    logic [ADDR_W-1:0]   r_ded_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Round-robin: when both sources pend, the one not served last wins.
    always_comb begin
        w_state_nxt = r_state;
        w_host_win  = 1'b0;
        w_scrub_win = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_host_win  = host_req && (!r_scrub_pend || !r_last_host);
                w_scrub_win = r_scrub_pend && !w_host_win;
                if (w_host_win || w_scrub_win) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ:  w_state_nxt = ST_CHECK;
            ST_CHECK: w_state_nxt = (dec_sec && !dec_ded) ? ST_WB : ST_IDLE;
            ST_WB:    w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr       <= '0;
            r_is_host    <= 1'b0;
            r_last_host  <= 1'b0;
            r_scrub_addr <= '0;
            r_timer      <= '0;
            r_scrub_pend <= 1'b0;
            r_rdata      <= '0;
            r_wcheck     <= '0;
            r_err        <= '0;
            r_rvalid     <= 1'b0;
            r_sec_cnt    <= '0;
            r_ded_cnt    <= '0;
            r_ded_addr   <= '0;
        end else begin
            r_rvalid <= 1'b0;
            if (w_host_win) begin
                r_addr      <= host_addr;
                r_is_host   <= 1'b1;
                r_last_host <= 1'b1;
            end else if (w_scrub_win) begin
                r_addr      <= r_scrub_addr;
                r_is_host   <= 1'b0;
                r_last_host <= 1'b0;
            end

            if (r_state == ST_CHECK) begin
                r_rdata  <= dec_data;
                r_wcheck <= dec_check;
                r_err    <= {dec_ded, dec_sec && !dec_ded};
                r_rvalid <= r_is_host;
                if (!r_is_host) begin
                    r_scrub_addr <= r_scrub_addr + ADDR_W'(1);
                end
                if (dec_ded) begin
                    r_ded_addr <= r_addr;
                    if (r_ded_cnt != C_CNT_MAX) begin
                        r_ded_cnt <= r_ded_cnt + CNT_W'(1);
                    end
                end else if (dec_sec) begin
                    if (r_sec_cnt != C_CNT_MAX) begin
                        r_sec_cnt <= r_sec_cnt + CNT_W'(1);
                    end
                end
            end

            // A fresh expiry wins over the grant that consumes the previous request.
            if (!scrub_en) begin
                r_timer      <= '0;
                r_scrub_pend <= 1'b0;
            end else if (r_timer == C_TMR_LAST) begin
                r_timer      <= '0;
                r_scrub_pend <= 1'b1;
            end else begin
                r_timer <= r_timer + TMR_W'(1);
                if (w_scrub_win) begin
                    r_scrub_pend <= 1'b0;
                end
            end
        end
    end

    assign host_gnt    = w_host_win && !reset;
    assign host_rvalid = r_rvalid;
    assign host_rdata  = r_rdata;
    assign host_err    = r_err;
    assign sram_addr   = r_addr;
    assign sram_re     = (r_state == ST_READ);
    assign sram_we     = (r_state == ST_WB);
    assign sram_wdata  = r_rdata;
    assign sram_wcheck = r_wcheck;
    assign dec_word    = {sram_rcheck, sram_rdata};
    assign sec_cnt     = r_sec_cnt;
    assign ded_cnt     = r_ded_cnt;
    assign ded_addr    = r_ded_addr;

endmodule

`default_nettype wire

// File: tb/tb_ecc_sram_scrub_ctrl.sv
// tb_ecc_sram_scrub_ctrl: SRAM/decoder stand-in, transaction-level reference model
// checked every cycle, plus directed scenarios with literal expectations.
`default_nettype none

module tb_ecc_sram_scrub_ctrl;

    localparam int AW       = 10;
    localparam int INTERVAL = 8;
    localparam int CW       = 3;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           host_req = 1'b0;
    logic [AW-1:0]  host_addr = '0;
    logic           host_gnt;
    logic           host_rvalid;
    logic [63:0]    host_rdata;
    logic [1:0]     host_err;
    logic           scrub_en = 1'b0;
    logic [AW-1:0]  sram_addr;
    logic           sram_re;
    logic           sram_we;
    logic [63:0]    sram_wdata;
    logic [7:0]     sram_wcheck;
    logic [63:0]    sram_rdata = '0;
    logic [7:0]     sram_rcheck = '0;
    logic [71:0]    dec_word;
    logic [63:0]    dec_data = '0;
    logic [7:0]     dec_check = '0;
    logic           dec_sec = 1'b0;
    logic           dec_ded = 1'b0;
    logic [CW-1:0]  sec_cnt;
    logic [CW-1:0]  ded_cnt;
    logic [AW-1:0]  ded_addr;

    ecc_sram_scrub_ctrl #(.ADDR_W(AW), .SCRUB_INTERVAL(INTERVAL), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .host_req(host_req), .host_addr(host_addr), .host_gnt(host_gnt),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata), .host_err(host_err),
        .scrub_en(scrub_en),
        .sram_addr(sram_addr), .sram_re(sram_re), .sram_we(sram_we),
        .sram_wdata(sram_wdata), .sram_wcheck(sram_wcheck),
        .sram_rdata(sram_rdata), .sram_rcheck(sram_rcheck),
        .dec_word(dec_word), .dec_data(dec_data), .dec_check(dec_check),
        .dec_sec(dec_sec), .dec_ded(dec_ded),
        .sec_cnt(sec_cnt), .ded_cnt(ded_cnt), .ded_addr(ded_addr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    // Stored word contents and error kind per address (0 clean, 1 SEC, 2 DED).
    function automatic logic [63:0] f_data(input logic [AW-1:0] a);
        return (a == 10'h010) ? 64'hA5A5_A5A5_A5A5_A5A5 : {6'd0, a, 48'h1234_5678_9ABC};
    endfunction

    function automatic logic [7:0] f_chk(input logic [AW-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    function automatic int f_kind(input logic [AW-1:0] a);
        if (a == 10'h3FF || a[6:0] == 7'd9) return 2;
        if (a == 10'h010 || a[5:0] == 6'd7) return 1;
        return 0;
    endfunction

    // SRAM answers the cycle after a read strobe; the decoder is an address lookup.
    bit            rd_v = 1'b0;
    logic [AW-1:0] rd_a = '0;
    always @(negedge clk) begin
        rd_v = sram_re && !reset;
        rd_a = sram_addr;
    end

    always @(posedge clk) begin
        #1;
        if (rd_v) begin
            int k;
            k = f_kind(rd_a);
            sram_rdata  = f_data(rd_a) ^ ((k == 1) ? 64'h1 : (k == 2) ? 64'h3 : 64'h0);
            sram_rcheck = f_chk(rd_a);
            dec_data    = f_data(rd_a);
            dec_check   = f_chk(rd_a);
            dec_sec     = (k != 0);
            dec_ded     = (k == 2);
        end else begin
            sram_rdata  = {$urandom, $urandom};
            sram_rcheck = 8'($urandom);
            dec_data    = {$urandom, $urandom};
            dec_check   = 8'($urandom);
            dec_sec     = 1'b0;
            dec_ded     = 1'b0;
        end
    end

    // Reference model: each grant schedules its future effects by absolute cycle.
    logic [AW-1:0] e_re_a [int];
    logic [AW-1:0] e_we_a [int];
    logic [63:0]   e_we_d [int];
    logic [7:0]    e_we_c [int];
    logic [63:0]   e_rv_d [int];
    logic [1:0]    e_rv_e [int];
    int            u_kind [int];
    logic [AW-1:0] u_addr [int];

    int            m_free = 0;
    int            m_timer = 0;
    bit            m_pend = 1'b0;
    bit            m_last_host = 1'b0;
    logic [AW-1:0] m_scrub = '0;
    int            m_sec = 0;
    int            m_ded = 0;
    logic [AW-1:0] m_dedaddr = '0;
    localparam int CMAX = (1 << CW) - 1;

    always @(negedge clk) begin
        int c;
        c = cyc;
        if (reset) begin
            e_re_a.delete(); e_we_a.delete(); e_we_d.delete(); e_we_c.delete();
            e_rv_d.delete(); e_rv_e.delete(); u_kind.delete(); u_addr.delete();
            m_free = c + 1; m_timer = 0; m_pend = 0; m_last_host = 0; m_scrub = '0;
            m_sec = 0; m_ded = 0; m_dedaddr = '0;
            chk("rst_gnt", host_gnt, 0);
            chk("rst_re", sram_re, 0);
            chk("rst_we", sram_we, 0);
            chk("rst_rvalid", host_rvalid, 0);
            chk("rst_rdata", host_rdata, 0);
            chk("rst_err", host_err, 0);
            chk("rst_addr", sram_addr, 0);
            chk("rst_sec_cnt", sec_cnt, 0);
            chk("rst_ded_cnt", ded_cnt, 0);
            chk("rst_ded_addr", ded_addr, 0);
        end else begin
            bit e_gnt, sg;
            e_gnt = 0; sg = 0;
            if (u_kind.exists(c)) begin
                if (u_kind[c] == 2) begin
                    if (m_ded < CMAX) m_ded++;
                    m_dedaddr = u_addr[c];
                end else if (m_sec < CMAX) begin
                    m_sec++;
                end
                u_kind.delete(c); u_addr.delete(c);
            end
            if (c >= m_free && (host_req || m_pend)) begin
                bit hw;
                logic [AW-1:0] a;
                int k;
                hw = host_req && (!m_pend || !m_last_host);
                a  = hw ? host_addr : m_scrub;
                k  = f_kind(a);
                e_re_a[c + 1] = a;
                if (hw) begin
                    e_rv_d[c + 3] = f_data(a);
                    e_rv_e[c + 3] = (k == 2) ? 2'b10 : (k == 1) ? 2'b01 : 2'b00;
                end
                if (k == 1) begin
                    e_we_a[c + 3] = a; e_we_d[c + 3] = f_data(a); e_we_c[c + 3] = f_chk(a);
                    m_free = c + 4;
                end else begin
                    m_free = c + 3;
                end
                if (k != 0) begin
                    u_kind[c + 3] = k; u_addr[c + 3] = a;
                end
                if (hw) e_gnt = 1;
                else begin
                    sg = 1; m_scrub = m_scrub + 10'd1;
                end
                m_last_host = hw;
            end

            chk("gnt", host_gnt, e_gnt);
            chk("re", sram_re, e_re_a.exists(c));
            if (e_re_a.exists(c)) begin
                chk("re_addr", sram_addr, e_re_a[c]); e_re_a.delete(c);
            end
            chk("we", sram_we, e_we_a.exists(c));
            if (e_we_a.exists(c)) begin
                chk("we_addr", sram_addr, e_we_a[c]);
                chk("we_data", sram_wdata, e_we_d[c]);
                chk("we_check", sram_wcheck, e_we_c[c]);
                e_we_a.delete(c); e_we_d.delete(c); e_we_c.delete(c);
            end
            chk("rvalid", host_rvalid, e_rv_d.exists(c));
            if (e_rv_d.exists(c)) begin
                chk("rdata", host_rdata, e_rv_d[c]);
                chk("err", host_err, e_rv_e[c]);
                e_rv_d.delete(c); e_rv_e.delete(c);
            end
            chk("sec_cnt", sec_cnt, m_sec);
            chk("ded_cnt", ded_cnt, m_ded);
            chk("ded_addr", ded_addr, m_dedaddr);

            if (!scrub_en) begin
                m_timer = 0; m_pend = 0;
            end else if (m_timer == INTERVAL - 1) begin
                m_timer = 0; m_pend = 1;
            end else begin
                m_timer++;
                if (sg) m_pend = 0;
            end
        end
        chk("dec_word", dec_word, {sram_rcheck, sram_rdata});
    end

    task automatic host_read(input logic [AW-1:0] a, input logic [1:0] xerr, input logic [63:0] xdata);
        bit got;
        got = 0;
        @(posedge clk); #1 host_req = 1; host_addr = a;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (host_gnt) begin got = 1; break; end
        end
        chk("gnt_seen", got, 1);
        @(posedge clk); #1 host_req = 0;
        @(negedge clk);
        chk("t1_re", sram_re, 1);
        chk("t1_addr", sram_addr, a);
        @(negedge clk);
        @(negedge clk);
        chk("t3_rvalid", host_rvalid, 1);
        chk("t3_err", host_err, xerr);
        chk("t3_rdata", host_rdata, xdata);
        chk("t3_we", sram_we, xerr == 2'b01);
        if (xerr == 2'b01) begin
            chk("t3_wb_addr", sram_addr, a);
            chk("t3_wb_data", sram_wdata, xdata);
        end
    endtask

    initial begin
        int nre, c1, c2, hosts, scrubs, consec, maxc, rv_seen;
        logic [AW-1:0] a1, a2, alast;
        bit last_gnt, gs;

        repeat (3) @(posedge clk);
        #1 reset = 0;
        repeat (2) @(posedge clk);

        host_read(10'h005, 2'b00, 64'h0005_1234_5678_9ABC);
        host_read(10'h010, 2'b01, 64'hA5A5_A5A5_A5A5_A5A5);
        @(negedge clk);
        chk("sec_cnt_after_sec", sec_cnt, 1);
        host_read(10'h3FF, 2'b10, 64'h03FF_1234_5678_9ABC);
        @(negedge clk);
        chk("ded_cnt_after_ded", ded_cnt, 1);
        chk("ded_addr_after_ded", ded_addr, 10'h3FF);

        // Background scrub through the whole array and back to address 0.
        @(posedge clk); #1 scrub_en = 1;
        nre = 0; c1 = 0; c2 = 0; a1 = '1; a2 = '1; alast = '1;
        for (int i = 0; i < 10000 && nre < 1025; i++) begin
            @(negedge clk);
            if (sram_re) begin
                nre++;
                if (nre == 1) begin a1 = sram_addr; c1 = cyc; end
                if (nre == 2) begin a2 = sram_addr; c2 = cyc; end
                if (nre == 1025) alast = sram_addr;
            end
        end
        chk("scrub_reads", nre, 1025);
        chk("scrub_first_addr", a1, 10'h000);
        chk("scrub_second_addr", a2, 10'h001);
        chk("scrub_period", c2 - c1, INTERVAL);
        chk("scrub_wrap_addr", alast, 10'h000);
        chk("sec_cnt_saturated", sec_cnt, 3'd7);
        chk("ded_cnt_saturated", ded_cnt, 3'd7);
        chk("ded_addr_last", ded_addr, 10'h3FF);
        @(posedge clk); #1 scrub_en = 0;
        repeat (6) @(posedge clk);

        // Host requesting back-to-back against periodic scrub requests.
        #1 host_addr = 10'h100; host_req = 1; scrub_en = 1;
        hosts = 0; scrubs = 0; consec = 0; maxc = 0; last_gnt = 0;
        for (int i = 0; i < 240; i++) begin
            @(negedge clk);
            if (sram_re) begin
                if (last_gnt) begin
                    hosts++; consec = 0;
                end else begin
                    scrubs++; consec++;
                    if (consec > maxc) maxc = consec;
                end
            end
            last_gnt = host_gnt;
            gs = host_gnt;
            @(posedge clk); #1;
            if (gs) host_addr = host_addr + 10'd1;
        end
        host_req = 0; scrub_en = 0;
        chk("rr_max_consec_scrub", maxc <= 1, 1);
        chk("rr_scrubs_served", scrubs >= 20, 1);
        chk("rr_hosts_served", hosts >= 20, 1);
        repeat (6) @(posedge clk);

        // Reset asserted in the middle of a write-back.
        host_read(10'h010, 2'b01, 64'hA5A5_A5A5_A5A5_A5A5);
        #1 reset = 1;
        #1;
        chk("rst_drops_we", sram_we, 0);
        chk("rst_drops_re", sram_re, 0);
        repeat (2) @(posedge clk);
        #1 reset = 0;
        rv_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (host_rvalid) rv_seen++;
        end
        chk("no_rvalid_after_rst", rv_seen, 0);
        chk("sec_cnt_after_rst", sec_cnt, 0);
        chk("ded_cnt_after_rst", ded_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ecc_sram_scrub_ctrl.md
Name: ecc_sram_scrub_ctrl

Overview:
- Sequences all reads of the ECC-protected 64+8-bit SRAM.
- Arbitrates between host read requests and a periodic background scrubber.
- Presents the 72-bit word {check[7:0], data[63:0]} to the SECDED decoder and returns corrected data to the host.
- Writes corrected data and check bits back on single-bit errors, and counts and logs errors.

Parameters:
- ADDR_W, 10, SRAM word-address width (depth 2^ADDR_W).
- SCRUB_INTERVAL, 1024, clk cycles between scrub requests (minimum 8).
- CNT_W, 16, width of the saturating error counters.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- host_req  in  1  host read request; held high until granted
- host_addr  in  ADDR_W  host read address; sampled when host_gnt=1
- host_gnt  out  1  one-cycle grant pulse
- host_rvalid  out  1  one-cycle read-data-valid pulse
- host_rdata  out  64  corrected read data
- host_err  out  2  {ded, sec} status qualified by host_rvalid
- scrub_en  in  1  enables background scrubbing
- sram_addr  out  ADDR_W  SRAM address
- sram_re  out  1  SRAM read strobe; data returns next cycle
- sram_we  out  1  SRAM write strobe
- sram_wdata  out  64  write-back data
- sram_wcheck  out  8  write-back check bits
- sram_rdata  in  64  SRAM read data
- sram_rcheck  in  8  SRAM read check bits
- dec_word  out  72  {sram_rcheck, sram_rdata}, combinational to the decoder
- dec_data  in  64  corrected data from the decoder (combinational path)
- dec_check  in  8  re-encoded check bits for dec_data
- dec_sec  in  1  single-bit error corrected
- dec_ded  in  1  uncorrectable double-bit error
- sec_cnt  out  CNT_W  saturating SEC count
- ded_cnt  out  CNT_W  saturating DED count
- ded_addr  out  ADDR_W  address of the most recent DED

Behaviour:
- Reset (asynchronous):
  - FSM=IDLE; scrub address, timer and pending flag = 0.
  - Every output = 0 except dec_word, which stays combinational.
  - Reset mid-operation drops sram_we/sram_re immediately; any in-flight transaction is abandoned with no rvalid.
- FSM states: IDLE, READ, CHECK, WB.
  - IDLE -> READ when host_req=1 or scrub_pend=1.
  - READ -> CHECK unconditionally.
  - CHECK -> WB if dec_sec=1 and dec_ded=0, else CHECK -> IDLE.
  - WB -> IDLE.
- Arbitration in IDLE:
  - If only one source is pending, it wins.
  - If both are pending, the source not served last wins (round-robin flag updated on each grant). Initial priority after reset is host.
  - host_gnt=1 combinationally in IDLE when host wins; host_addr is captured that cycle.
  - A scrub grant captures the scrub address and clears scrub_pend.
- Host read timing (gnt at cycle T):
  - T+1 READ: sram_re=1, sram_addr=captured address.
  - T+2 CHECK: decoder outputs sampled into registers.
  - T+3: host_rvalid=1, host_rdata=dec_data sample, host_err={ded,sec}. If sec=1, state=WB with sram_we=1, sram_addr=same address, sram_wdata/sram_wcheck=sampled dec_data/dec_check.
  - Next grant is possible at T+3 (no SEC) or T+4 (after WB).
- Error classification: dec_sec=1 together with dec_ded=1 is treated as DED. DED performs no write-back.
- Scrub transaction: same sequence as a host read with no host_rvalid. The scrub address increments after CHECK and wraps from 2^ADDR_W-1 to 0.
- Scrub timer:
  - Counts while scrub_en=1; at SCRUB_INTERVAL-1 it sets scrub_pend and reloads 0.
  - If the timer expires while scrub_pend is already set, the request is dropped (no queuing).
  - scrub_en=0 clears the timer and scrub_pend; an in-flight scrub still completes.
- Counters:
  - sec_cnt/ded_cnt increment by 1 in the cycle after CHECK, for both host and scrub transactions.
  - They saturate at 2^CNT_W-1, with no wrap.
  - ded_addr loads the transaction address on each DED.
- sram_re and sram_we are never asserted in the same cycle. Outside READ/WB, sram_addr holds its last value.

Test Plan:
1. After reset, host_req=1, addr=0x005, clean word -> host_gnt at T; sram_re at T+1 with sram_addr=0x005; host_rvalid at T+3 with host_err=00 and rdata=dec_data; no sram_we.
2. Host read at 0x010 with dec_sec=1, dec_data=0xA5A5_A5A5_A5A5_A5A5 -> host_err=01 at T+3; sram_we=1 at T+3 with addr 0x010 and wdata=0xA5A5_A5A5_A5A5_A5A5; sec_cnt=1.
3. dec_ded=1 (also dec_sec=1) at addr 0x3FF -> host_err=10, no sram_we, ded_cnt=1, ded_addr=0x3FF.
4. scrub_en=1, SCRUB_INTERVAL=8, no host traffic -> a scrub read every 8 cycles at addresses 0,1,2,...; after 1024 scrubs the address wraps to 0.
5. host_req held high continuously with scrub_pend set -> grants alternate host/scrub; the host is never starved for more than one transaction.
6. Assert reset during WB -> sram_we drops immediately; after release, FSM=IDLE, counters=0, no host_rvalid.
